display_scan_controller: RTL and testbench

Sequences the 4-digit multiplexed seven-segment display. Time-slices the digits with a programmable slot period and an anti-ghosting blank guard, and drives the 2-bit `sync_count` consumed by the cathode decoder. Presents the nibble, decimal point and an on-flag for the current digit to the segment decoder. Accepts new 16-bit display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never tears.

---
 rtl/display_pkg.sv | 17 +
 rtl/scan_tick_gen.sv | 40 ++++
 rtl/display_scan_controller.sv | 169 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned DIGIT_IDX_W = 2;
    localparam int unsigned VALUE_W     = 4 * NUM_DIGITS;

    localparam int unsigned DEFAULT_TICK_DIV     = 100000;
    localparam int unsigned DEFAULT_GUARD_CYCLES = 2000;

    typedef enum logic [1:0] {
        StOff,
        StBlank,
        StShow
    } scan_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..TICK_DIV-1 with synchronous clear, strobing guard and slot ends.
module scan_tick_gen
    import display_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic guard_end_o,
    output logic slot_end_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] SlotLast  = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] GuardLast = (GUARD_CYCLES == 0) ? '0 : CntW'(GUARD_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign slot_end_o  = (cnt_q == SlotLast);
    // With no guard there is no blank phase, so the strobe must never fire.
    assign guard_end_o = (GUARD_CYCLES != 0) && (cnt_q == GuardLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || slot_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan sequencer with frame-synchronous value update.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [VALUE_W-1:0]     value_i,
    input  logic [NUM_DIGITS-1:0]  dp_i,
    input  logic                   value_valid_i,
    output logic                   value_ready_o,
    output logic [DIGIT_IDX_W-1:0] sync_count_o,
    output logic [3:0]             digit_nibble_o,
    output logic                   dp_o,
    output logic                   digit_on_o,
    output logic                   frame_done_o
);

    localparam scan_state_t SlotStart = (GUARD_CYCLES == 0) ? StShow : StBlank;
    localparam logic [DIGIT_IDX_W-1:0] LastDigit = DIGIT_IDX_W'(NUM_DIGITS - 1);

    scan_state_t state_q, state_d;

    logic [DIGIT_IDX_W-1:0] sync_q, sync_d;
    logic [VALUE_W-1:0]     act_val_q, act_val_d, sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic                   pend_q, pend_d;
    logic                   frame_q, frame_d;
    logic                   on_q, on_d;
    logic                   dp_q, dp_d;
    logic [3:0]             nib_q, nib_d;
    logic                   blank_d;
    logic                   accept;
    logic                   guard_end, slot_end;

    scan_tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_tick (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     ((state_q == StOff) || !enable_i),
        .guard_end_o (guard_end),
        .slot_end_o  (slot_end)
    );

`ifdef DISPLAY_LZB_EN
    // Digit k (k >= 1) is a leading zero when nibbles k..3 are all zero.
    function automatic logic lz_blank(logic [DIGIT_IDX_W-1:0] idx, logic [VALUE_W-1:0] val);
        unique case (idx)
            2'd1:    return (val[15:4] == '0);
            2'd2:    return (val[15:8] == '0);
            2'd3:    return (val[15:12] == '0);
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign accept        = value_valid_i && !pend_q;
    assign value_ready_o = !pend_q;

    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        pend_d    = pend_q;
        frame_d   = 1'b0;

        // Accept only when empty, so it never collides with a shadow-to-active copy.
        if (accept) begin
            sh_val_d = value_i;
            sh_dp_d  = dp_i;
            pend_d   = 1'b1;
        end

        unique case (state_q)
            StOff: begin
                sync_d = '0;
                if (pend_q) begin
                    act_val_d = sh_val_q;
                    act_dp_d  = sh_dp_q;
                    pend_d    = 1'b0;
                end
                if (enable_i) begin
                    state_d = SlotStart;
                end
            end
            StBlank: begin
                if (!enable_i) begin
                    state_d = StOff;
                    sync_d  = '0;
                end else if (guard_end) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (!enable_i) begin
                    state_d = StOff;
                    sync_d  = '0;
                end else if (slot_end) begin
                    state_d = SlotStart;
                    sync_d  = sync_q + DIGIT_IDX_W'(1);
                    if (sync_q == LastDigit) begin
                        frame_d = 1'b1;
                        if (pend_q) begin
                            act_val_d = sh_val_q;
                            act_dp_d  = sh_dp_q;
                            pend_d    = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase

`ifdef DISPLAY_LZB_EN
        blank_d = lz_blank(sync_d, act_val_d);
`else
        blank_d = 1'b0;
`endif
        nib_d = act_val_d[{sync_d, 2'b00} +: 4];
        dp_d  = act_dp_d[sync_d] && !blank_d;
        on_d  = (state_d == StShow) && !blank_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StOff;
            sync_q    <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            pend_q    <= 1'b0;
            frame_q   <= 1'b0;
            on_q      <= 1'b0;
            dp_q      <= 1'b0;
            nib_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            pend_q    <= pend_d;
            frame_q   <= frame_d;
            on_q      <= on_d;
            dp_q      <= dp_d;
            nib_q     <= nib_d;
        end
    end

    assign sync_count_o   = sync_q;
    assign digit_nibble_o = nib_q;
    assign dp_o           = dp_q;
    assign digit_on_o     = on_q;
    assign frame_done_o   = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a time-based reference model predicts every cycle's outputs.
module tb_display_scan_controller;

    localparam int unsigned TD = 8;
    localparam int unsigned GC = 2;
    localparam int FRAME = 4 * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        value_valid = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        value_ready, dp_out, digit_on, frame_done;
    logic [1:0]  sync_count;
    logic [3:0]  digit_nibble;

    display_scan_controller #(
        .TICK_DIV     (TD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .value_i        (value),
        .dp_i           (dp),
        .value_valid_i  (value_valid),
        .value_ready_o  (value_ready),
        .sync_count_o   (sync_count),
        .digit_nibble_o (digit_nibble),
        .dp_o           (dp_out),
        .digit_on_o     (digit_on),
        .frame_done_o   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sync;
        logic [3:0] nib;
        logic       dp;
        logic       on;
        logic       frame;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    // Reference model: scanning time m_n since the enable edge fixes digit and phase.
    bit m_scan = 0;
    int m_n = 0;
    int m_act_val = 0, m_act_dp = 0, m_sh_val = 0, m_sh_dp = 0;
    bit m_pend = 0;

    function automatic exp_t model_out(bit fr);
        exp_t e;
        int   d;
        bit   blank;
        d     = m_scan ? (m_n / TD) % 4 : 0;
        blank = 1'b0;
`ifdef DISPLAY_LZB_EN
        if (d > 0 && (m_act_val >> (4 * d)) == 0) blank = 1'b1;
`endif
        e.sync  = 2'(d);
        e.nib   = 4'((m_act_val >> (4 * d)) & 15);
        e.dp    = blank ? 1'b0 : 1'(((m_act_dp >> d) & 1));
        e.on    = m_scan && ((m_n % TD) >= GC) && !blank;
        e.frame = fr;
        e.ready = !m_pend;
        return e;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        bit fr;
        fr = 1'b0;
        cycle++;
        if (rst) begin
            m_scan = 0; m_n = 0; m_pend = 0;
            m_act_val = 0; m_act_dp = 0; m_sh_val = 0; m_sh_dp = 0;
        end else begin
            acc = value_valid && !m_pend;
            if (!m_scan) begin
                if (m_pend) begin
                    m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_pend = 0;
                end
                if (enable) begin
                    m_scan = 1; m_n = 0;
                end
            end else if (!enable) begin
                m_scan = 0; m_n = 0;
            end else begin
                m_n++;
                if (m_n % FRAME == 0) begin
                    fr = 1'b1;
                    if (m_pend) begin
                        m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_pend = 0;
                    end
                end
            end
            if (acc) begin
                m_sh_val = int'(value); m_sh_dp = int'(dp); m_pend = 1;
            end
        end
        exp_q.push_back(model_out(fr));
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {sync_count, digit_nibble, dp_out, digit_on, frame_done, value_ready};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got sync=%0d nib=%h dp=%b on=%b frame=%b ready=%b, expected sync=%0d nib=%h dp=%b on=%b frame=%b ready=%b",
                         cycle, got.sync, got.nib, got.dp, got.on, got.frame, got.ready,
                         e.sync, e.nib, e.dp, e.on, e.frame, e.ready);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        int k;
        value = v; dp = d; value_valid = 1'b1; k = 0;
        while (!value_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL send timeout: ready stayed %b, required 1", value_ready);
        end
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_phase(input int target);
        int k;
        k = 0;
        while (!(m_scan && (m_n % FRAME) == target && !m_pend) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL wait_phase timeout: phase %0d, required %0d", m_n % FRAME, target);
        end
    endtask

    initial begin
        logic [15:0] rv;
        tick(3);
        rst = 1'b0;
        tick(2);
        send(16'h1234, 4'b0100);
        enable = 1'b1;
        tick(70);
        wait_phase(10);
        send(16'hABCD, 4'b0001);
        tick(70);
        send(16'h5555, 4'b1010);
        send(16'h6666, 4'b0101);
        tick(100);
        wait_phase(31);
        send(16'h0050, 4'b1111);
        tick(70);
        wait_phase(19);
        send(16'h9876, 4'b1111);
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(40);
        wait_phase(5);
        send(16'h4321, 4'b0011);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        send(16'h0050, 4'b1100);
        tick(70);
        for (int i = 0; i < 3000; i++) begin
            rv = 16'($urandom);
            case ($urandom_range(0, 3))
                1: rv = rv & 16'h0FFF;
                2: rv = rv & 16'h00FF;
                3: rv = rv & 16'h000F;
                default: ;
            endcase
            value       = rv;
            dp          = 4'($urandom);
            value_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) enable = !enable;
            rst = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        value_valid = 1'b0;
        rst = 1'b0;
        enable = 1'b1;
        tick(5);
        n_checks++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, required at most 1", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
